// File: rtl/conv_frame_ctrl_if.sv
// Chunk stream handshake around the convolution frame sequencer.
// The s_* pair faces upstream and the m_* pair faces the filter input.
interface conv_frame_ctrl_if;
    logic s_vld;
    logic s_rdy;
    logic m_vld;
    logic m_rdy;

    modport master (output s_vld, output m_rdy, input s_rdy, input m_vld);
    modport slave  (input s_vld, input m_rdy, output s_rdy, output m_vld);
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the convolution filter: gates the chunk stream per frame,
// tracks column/row of each beat and waits out the filter latency before done.
module conv_frame_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int LAT    = 2,
    parameter int KSEL_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      cfg_en,
    input  logic [KSEL_W-1:0]         cfg_ksel,
    conv_frame_ctrl_if.slave          stream,
    output logic                      filt_en,
    output logic [KSEL_W-1:0]         ksel,
    output logic [$clog2(WIDTH)-1:0]  col,
    output logic [$clog2(HEIGHT)-1:0] row,
    output logic                      sof,
    output logic                      eol,
    output logic                      eof,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic [15:0]               frame_cnt
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int DW = $clog2(LAT + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(LAT);
    localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic          run;
    logic          beat;

    // The stream is a pure pass-through while a frame runs and fully blocked otherwise.
    assign run          = (state == RUN);
    assign stream.m_vld = run & stream.s_vld;
    assign stream.s_rdy = run & stream.m_rdy;
    assign beat         = stream.m_vld & stream.m_rdy;

    assign sof = beat & (col == '0) & (row == '0);
    assign eol = beat & (col == COL_LAST);
    assign eof = eol & (row == ROW_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            filt_en   <= 1'b0;
            ksel      <= '0;
            col       <= '0;
            row       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    // Configuration is sampled only here so it stays fixed for the whole frame.
                    if (start) begin
                        filt_en <= cfg_en;
                        ksel    <= cfg_ksel;
                        col     <= '0;
                        row     <= '0;
                        state   <= RUN;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        col     <= '0;
                        row     <= '0;
                    end else if (beat) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row       <= '0;
                                drain_cnt <= DRAIN_LOAD;
                                state     <= DRAIN;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Last beat is still inside the filter; hold done until it emerges.
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        col     <= '0;
                        row     <= '0;
                    end else if (drain_cnt == DRAIN_ONE) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Randomised scoreboard bench for conv_frame_ctrl: a beat-count frame model
// predicts every cycle's outputs plus done/aborted pulses; a monitor checks them.
module tb_conv_frame_ctrl;
    localparam int W = 4, H = 2, LAT = 2, KW = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

    logic          clk = 1'b0;
    logic          rst, start, abort, cfg_en;
    logic [KW-1:0] cfg_ksel;
    logic          filt_en, sof, eol, eof, busy, done, aborted;
    logic [KW-1:0] ksel;
    logic [1:0]    col;
    logic [0:0]    row;
    logic [15:0]   frame_cnt;

    conv_frame_ctrl_if ifc ();

    conv_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .LAT(LAT), .KSEL_W(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_en(cfg_en),
        .cfg_ksel(cfg_ksel), .stream(ifc.slave), .filt_en(filt_en), .ksel(ksel),
        .col(col), .row(row), .sof(sof), .eol(eol), .eof(eof), .busy(busy),
        .done(done), .aborted(aborted), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          s_rdy;
        logic          m_vld;
        logic          busy;
        logic          fen;
        logic [KW-1:0] ks;
        logic [1:0]    col;
        logic [0:0]    row;
        logic          sof;
        logic          eol;
        logic          eof;
        logic [15:0]   fc;
    } obs_t;

    typedef struct packed {
        int          cyc;
        logic [15:0] fc;
    } done_t;

    obs_t  exp_q[$];
    done_t done_q[$];
    int    ab_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Frame model: position is just the number of accepted beats in the frame.
    int            mode = M_IDLE;
    int            k = 0;
    int            dleft = 0;
    logic [15:0]   fcnt = '0;
    logic          en_l = 1'b0;
    logic [KW-1:0] ks_l = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        obs_t  e, a;
        done_t d;
        int    ac;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {ifc.s_rdy, ifc.m_vld, busy, filt_en, ksel, col, row, sof, eol, eof, frame_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d act(rdy,vld,busy,en,ks,col,row,sof,eol,eof,fc)=%b,%b,%b,%b,%0d,%0d,%0d,%b,%b,%b,%h req=%b,%b,%b,%b,%0d,%0d,%0d,%b,%b,%b,%h",
                         cyc, a.s_rdy, a.m_vld, a.busy, a.fen, a.ks, a.col, a.row, a.sof, a.eol, a.eof, a.fc,
                         e.s_rdy, e.m_vld, e.busy, e.fen, e.ks, e.col, e.row, e.sof, e.eol, e.eof, e.fc);
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d act done=1 req done=0", cyc);
            end else begin
                d = done_q.pop_front();
                if (d.cyc != cyc || d.fc !== frame_cnt) begin
                    errors++;
                    $display("FAIL done_timing act cyc=%0d fc=%h req cyc=%0d fc=%h", cyc, frame_cnt, d.cyc, d.fc);
                end
            end
        end
        if (aborted === 1'b1) begin
            checks++;
            if (ab_q.size() == 0) begin
                errors++;
                $display("FAIL aborted_unexpected cyc=%0d act aborted=1 req aborted=0", cyc);
            end else begin
                ac = ab_q.pop_front();
                if (ac != cyc) begin
                    errors++;
                    $display("FAIL aborted_timing act cyc=%0d req cyc=%0d", cyc, ac);
                end
            end
        end
    end

    // One clock cycle of stimulus; the model predicts this cycle and the next state.
    task automatic step(input logic st, input logic ab, input logic ce, input logic [KW-1:0] ck,
                        input logic sv, input logic mr);
        obs_t e;
        logic bt;
        @(posedge clk);
        #1;
        start = st; abort = ab; cfg_en = ce; cfg_ksel = ck;
        ifc.s_vld = sv; ifc.m_rdy = mr;
        bt = (mode == M_RUN) && sv && mr;
        e.s_rdy = (mode == M_RUN) && mr;
        e.m_vld = (mode == M_RUN) && sv;
        e.busy  = (mode != M_IDLE);
        e.fen   = en_l;
        e.ks    = ks_l;
        e.col   = 2'(k % W);
        e.row   = 1'(k / W);
        e.sof   = bt && (k == 0);
        e.eol   = bt && (k % W == W - 1);
        e.eof   = bt && (k == W * H - 1);
        e.fc    = fcnt;
        exp_q.push_back(e);
        if (mode == M_IDLE) begin
            if (st) begin
                en_l = ce; ks_l = ck; k = 0; mode = M_RUN;
            end
        end else if (ab) begin
            ab_q.push_back(cyc + 1);
            k = 0; mode = M_IDLE;
        end else if (mode == M_RUN) begin
            if (bt) begin
                k++;
                if (k == W * H) begin
                    k = 0; dleft = LAT; mode = M_DRAIN;
                end
            end
        end else begin
            dleft--;
            if (dleft == 0) begin
                fcnt = fcnt + 16'd1;
                done_q.push_back('{cyc: cyc + 1, fc: fcnt});
                mode = M_IDLE;
            end
        end
    endtask

    function automatic logic pct(input int p);
        return $urandom_range(99) < p;
    endfunction

    task automatic wait_idle(input int bound, input int pv, input int pr, input int ps, input int pa);
        int n = 0;
        while (mode != M_IDLE && n < bound) begin
            step(pct(ps), pct(pa), 1'($urandom), 2'($urandom), pct(pv), pct(pr));
            n++;
        end
        if (mode != M_IDLE) begin
            checks++; errors++;
            $display("FAIL frame_bound act still busy after %0d cycles req idle", bound);
        end
    endtask

    task automatic chk_zero(input string name);
        logic [31:0] a;
        a = {ifc.s_rdy, ifc.m_vld, busy, filt_en, ksel, col, row, done, aborted, sof, eol, eof, frame_cnt};
        checks++;
        if (a !== '0) begin
            errors++;
            $display("FAIL %s act=%h req=0", name, a);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0; start = 1'b0; abort = 1'b0; ifc.s_vld = 1'b1; ifc.m_rdy = 1'b1;
        mode = M_IDLE; k = 0; fcnt = '0; en_l = 1'b0; ks_l = '0;
        done_q.delete(); ab_q.delete();
        #2;
        chk_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_hold");
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; cfg_en = 1'b0; cfg_ksel = '0;
        ifc.s_vld = 1'b0; ifc.m_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_state");
        rst = 1'b1;
        repeat (2) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);

        // Back-to-back frame with cfg_en=1, ksel=2.
        step(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        for (int i = 0; i < W * H; i++) step(1'b0, 1'b0, 1'b0, 2'($urandom), 1'b1, 1'b1);
        wait_idle(10, 100, 100, 0, 0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);

        // m_rdy toggling, cfg changing under a running frame.
        step(1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 40 && mode == M_RUN; i++)
            step(1'b0, 1'b0, 1'($urandom), 2'($urandom), 1'b1, 1'(i % 2 == 0));
        wait_idle(10, 100, 100, 0, 0);

        // Abort after 5 beats (abort with a same-cycle beat), then restart at once.
        step(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1);
        wait_idle(40, 100, 100, 0, 0);

        // start held during RUN and DRAIN is ignored; start in the done cycle is accepted.
        step(1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1);
        for (int i = 0; i < 40 && mode != M_IDLE; i++)
            step(1'b1, 1'b0, 1'($urandom), 2'($urandom), 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1);
        wait_idle(40, 80, 80, 50, 0);

        // Abort during DRAIN.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 40 && mode != M_DRAIN; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);

        // Frame counter wrap from 0xFFFF.
        @(negedge clk);
        #1;
        force dut.frame_cnt = 16'hFFFF;
        fcnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        step(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
        wait_idle(40, 90, 90, 0, 0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);

        // Reset while DRAIN holds counter=1.
        step(1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1);
        for (int i = 0; i < 40 && !(mode == M_DRAIN && dleft == 1); i++)
            step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        do_reset();
        repeat (3) step(1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1);

        // Random frames with stalls, stray starts and occasional aborts.
        for (int f = 0; f < 40; f++) begin
            step(1'b1, 1'b0, 1'($urandom), 2'($urandom), pct(60), pct(60));
            wait_idle(300, 70, 70, 10, 3);
            repeat ($urandom_range(2)) step(pct(20), pct(20), 1'($urandom), 2'($urandom), pct(50), pct(50));
            wait_idle(300, 70, 70, 0, 0);
        end

        repeat (4) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        checks++;
        if (done_q.size() != 0 || ab_q.size() != 0) begin
            errors++;
            $display("FAIL pending_pulses act done_q=%0d ab_q=%0d req 0,0", done_q.size(), ab_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
